// File: rtl/next_pc_predict.sv
// Fetch-stage next-PC selection with a direct-mapped BTB and 2-bit counters.
// Mispredicts detected in EX redirect fetch and flush the younger stages.
module next_pc_predict #(
  parameter int          ENTRIES  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc_cur,
  input  logic        ex_valid,
  input  logic        ex_is_cf,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] pc_next,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush,
  output logic [15:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, ex_idx;
  logic [TAG_W-1:0] lk_tag, ex_tag;
  btb_entry_t       lk_entry, ex_entry;
  logic             lk_hit, ex_hit;
  logic [31:0]      pc_plus4, ex_plus4;
  logic             mispredict;
  logic             btb_update;

  // The low two PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_cur[1:0], ex_pc[1:0]};

  assign lk_idx   = pc_cur[IDX_W+1:2];
  assign lk_tag   = pc_cur[31:IDX_W+2];
  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign ex_tag   = ex_pc[31:IDX_W+2];
  assign lk_entry = btb_q[lk_idx];
  assign ex_entry = btb_q[ex_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  // 32-bit adds wrap naturally at the top of the address space.
  assign pc_plus4 = pc_cur + 32'd4;
  assign ex_plus4 = ex_pc + 32'd4;

  assign pred_taken  = !rst && lk_hit && lk_entry.ctr[1];
  assign pred_target = lk_hit ? lk_entry.target : pc_plus4;

  assign mispredict = !rst && ex_valid && ex_is_cf &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
  assign flush      = mispredict;
  assign btb_update = ex_valid && ex_is_cf;

  // NOTE: always_comb with every output given a default first, so no latch can be inferred.
  always_comb begin
    pc_next = pc_plus4;
    if (rst)             pc_next = RESET_PC;
    else if (mispredict) pc_next = ex_taken ? ex_target : ex_plus4;
    else if (stall)      pc_next = pc_cur;
    else if (pred_taken) pc_next = pred_target;
  end

  // Lookup reads btb_q combinationally, so a same-cycle update is only seen next cycle.
  // NOTE: the BTB array is reset explicitly because lookups must miss immediately after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (btb_update) begin
      if (ex_hit) begin
        if (ex_taken) begin
          btb_q[ex_idx].target <= ex_target;
          if (ex_entry.ctr != 2'b11) btb_q[ex_idx].ctr <= ex_entry.ctr + 2'd1;
        end else if (ex_entry.ctr != 2'b00) begin
          btb_q[ex_idx].ctr <= ex_entry.ctr - 2'd1;
        end
      end else if (ex_taken) begin
        btb_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: 2'b10};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispred_cnt <= '0;
    end else if (mispredict && (mispred_cnt != 16'hFFFF)) begin
      mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule
